// File: rtl/uart_tx_frame.sv
// UART transmit serializer: start bit, 8 data bits LSB first, optional parity, stop bit.
// Each bit is held for BAUD_DIV clocks, where BAUD_DIV = CLK_FREQ / BAUD_RATE.
module uart_tx_frame #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int PARITY    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       uart_txd
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);
  localparam bit HAS_PARITY = (PARITY == 1) || (PARITY == 2);
  localparam bit ODD_PARITY = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             parity_reg;
  logic             bit_end;

  assign bit_end = (cnt_reg == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      uart_txd    <= 1'b1;
    end else begin
      tx_done <= 1'b0;
      if (state_reg != S_IDLE) begin
        cnt_reg <= bit_end ? '0 : cnt_reg + 1'b1;
      end

      case (state_reg)
        S_IDLE: begin
          if (tx_req) begin
            shift_reg   <= tx_data;
            parity_reg  <= ODD_PARITY ? ~^tx_data : ^tx_data;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            tx_busy     <= 1'b1;
            uart_txd    <= 1'b0;
            state_reg   <= S_START;
          end
        end

        // The shift register always presents the next data bit in bit 0.
        S_START: begin
          if (bit_end) begin
            bit_idx_reg <= '0;
            uart_txd    <= shift_reg[0];
            shift_reg   <= {1'b0, shift_reg[7:1]};
            state_reg   <= S_DATA;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            if (bit_idx_reg == 3'd7) begin
              if (HAS_PARITY) begin
                uart_txd  <= parity_reg;
                state_reg <= S_PAR;
              end else begin
                uart_txd  <= 1'b1;
                state_reg <= S_STOP;
              end
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              uart_txd    <= shift_reg[0];
              shift_reg   <= {1'b0, shift_reg[7:1]};
            end
          end
        end

        S_PAR: begin
          if (bit_end) begin
            uart_txd  <= 1'b1;
            state_reg <= S_STOP;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            tx_busy   <= 1'b0;
            tx_done   <= 1'b1;
            state_reg <= S_IDLE;
          end
        end

        default: begin
          uart_txd  <= 1'b1;
          tx_busy   <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: one instance per parity mode (0 none, 1 odd, 2 even), BAUD_DIV=10.
// Expected line waveforms come from a frame-level model built as per-cycle queues.
module tb_uart_tx_frame;

  localparam int DIV = 10;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic [2:0] tx_req;
  logic [2:0] tx_busy;
  logic [2:0] tx_done;
  logic [2:0] uart_txd;

  int errors = 0;
  int checks = 0;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    uart_tx_frame #(
      .CLK_FREQ (1_000_000),
      .BAUD_RATE(100_000),
      .PARITY   (gi)
    ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .tx_req  (tx_req[gi]),
      .tx_data (tx_data),
      .tx_busy (tx_busy[gi]),
      .tx_done (tx_done[gi]),
      .uart_txd(uart_txd[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Per-cycle expectations, index 0 = first cycle after the acceptance edge.
  logic exp_txd[$];
  logic exp_busy[$];
  logic exp_done[$];
  logic obs_txd[$];
  int   obs_busy_cnt;

  task automatic clear_model();
    exp_txd.delete();
    exp_busy.delete();
    exp_done.delete();
  endtask

  task automatic add_frame(input int mode, input logic [7:0] d);
    logic bits[$];
    int   ones;
    ones = $countones(d);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (mode == 1) bits.push_back((ones % 2) == 0);
    if (mode == 2) bits.push_back((ones % 2) == 1);
    bits.push_back(1'b1);
    foreach (bits[k]) begin
      for (int r = 0; r < DIV; r++) begin
        exp_txd.push_back(bits[k]);
        exp_busy.push_back(1'b1);
        exp_done.push_back(1'b0);
      end
    end
    exp_txd.push_back(1'b1);
    exp_busy.push_back(1'b0);
    exp_done.push_back(1'b1);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_txd.push_back(1'b1);
      exp_busy.push_back(1'b0);
      exp_done.push_back(1'b0);
    end
  endtask

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_wave(input string name, input int bad, input int first_c,
                            input logic got, input logic req);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d cycles wrong, first at cycle %0d got %b required %b",
               name, bad, first_c, got, req);
    end
  endtask

  // Called at a negedge: request is seen at the next posedge (acceptance edge).
  task automatic start(input int u, input logic [7:0] d);
    tx_data   = d;
    tx_req[u] = 1'b1;
    @(negedge clk);
  endtask

  // Walks the expected queues, sampling at negedges; drives request release/stale pulses.
  task automatic observe(input int u, input string name, input int release_c,
                         input int stale_c, input logic [7:0] next_data);
    int   bt, bb, bd, ft, fb, fd;
    logic gt, gb, gd, rt, rb, rd;
    bt = 0; bb = 0; bd = 0; ft = 0; fb = 0; fd = 0;
    gt = 0; gb = 0; gd = 0; rt = 0; rb = 0; rd = 0;
    obs_txd.delete();
    obs_busy_cnt = 0;
    for (int c = 0; c < exp_txd.size(); c++) begin
      obs_txd.push_back(uart_txd[u]);
      if (tx_busy[u]) obs_busy_cnt++;
      if (uart_txd[u] !== exp_txd[c]) begin
        if (bt == 0) begin ft = c; gt = uart_txd[u]; rt = exp_txd[c]; end
        bt++;
      end
      if (tx_busy[u] !== exp_busy[c]) begin
        if (bb == 0) begin fb = c; gb = tx_busy[u]; rb = exp_busy[c]; end
        bb++;
      end
      if (tx_done[u] !== exp_done[c]) begin
        if (bd == 0) begin fd = c; gd = tx_done[u]; rd = exp_done[c]; end
        bd++;
      end
      if (c == 0) tx_data = next_data;
      if (c == release_c) tx_req[u] = 1'b0;
      if (stale_c >= 0 && c == stale_c) begin
        tx_req[u] = 1'b1;
        tx_data   = 8'hFF;
      end
      if (stale_c >= 0 && c == stale_c + 1) tx_req[u] = 1'b0;
      @(negedge clk);
    end
    check_wave({name, "_txd"}, bt, ft, gt, rt);
    check_wave({name, "_busy"}, bb, fb, gb, rb);
    check_wave({name, "_done"}, bd, fd, gd, rd);
  endtask

  typedef struct {
    int         unit;
    logic [7:0] data;
    int         exp_busy;
    bit         has_par;
    logic       exp_par;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int         u;
    logic [7:0] d;

    vecs[0] = '{0, 8'h55, 100, 1'b0, 1'b0};
    vecs[1] = '{2, 8'h03, 110, 1'b1, 1'b0};
    vecs[2] = '{1, 8'h03, 110, 1'b1, 1'b1};
    vecs[3] = '{2, 8'h07, 110, 1'b1, 1'b1};
    vecs[4] = '{1, 8'h00, 110, 1'b1, 1'b1};

    rst_n   = 1'b0;
    tx_req  = 3'b000;
    tx_data = 8'h00;

    // Reset then idle
    repeat (3) @(negedge clk);
    check_val("reset_txd", int'(uart_txd), 7);
    check_val("reset_busy", int'(tx_busy), 0);
    check_val("reset_done", int'(tx_done), 0);
    rst_n = 1'b1;
    clear_model();
    add_idle(200);
    observe(0, "idle", -1, -1, 8'h00);
    $display("txn idle     unit=0 cycles=200");

    // Directed table
    foreach (vecs[i]) begin
      clear_model();
      add_frame(vecs[i].unit, vecs[i].data);
      add_idle(3);
      start(vecs[i].unit, vecs[i].data);
      observe(vecs[i].unit, "vec", 0, -1, 8'($urandom));
      check_val("vec_busy_cycles", obs_busy_cnt, vecs[i].exp_busy);
      if (vecs[i].has_par) check_val("vec_parity_bit", int'(obs_txd[95]), int'(vecs[i].exp_par));
      $display("txn vec      unit=%0d data=0x%02h busy_cycles=%0d",
               vecs[i].unit, vecs[i].data, obs_busy_cnt);
    end

    // Request while busy is ignored
    clear_model();
    add_frame(0, 8'hA5);
    add_idle(30);
    start(0, 8'hA5);
    observe(0, "stale", 0, 40, 8'hA5);
    $display("txn stale    unit=0 data=0xa5 busy_cycles=%0d", obs_busy_cnt);

    // Back-to-back with tx_req held through the done cycle
    clear_model();
    add_frame(0, 8'h12);
    add_frame(0, 8'h34);
    add_idle(5);
    start(0, 8'h12);
    observe(0, "b2b", 101, -1, 8'h34);
    check_val("b2b_second_start", int'(obs_txd[101]), 0);
    $display("txn b2b      unit=0 data=0x12,0x34 busy_cycles=%0d", obs_busy_cnt);

    // Reset mid-frame
    clear_model();
    add_frame(0, 8'h00);
    while (exp_txd.size() > 35) begin
      void'(exp_txd.pop_back());
      void'(exp_busy.pop_back());
      void'(exp_done.pop_back());
    end
    start(0, 8'h00);
    observe(0, "midrst_pre", 0, -1, 8'h00);
    rst_n = 1'b0;
    #1;
    check_val("midrst_txd_async", int'(uart_txd[0]), 1);
    check_val("midrst_busy_async", int'(tx_busy[0]), 0);
    repeat (3) @(negedge clk);
    check_val("midrst_done_in_reset", int'(tx_done[0]), 0);
    rst_n = 1'b1;
    clear_model();
    add_idle(100);
    observe(0, "midrst_idle", -1, -1, 8'h00);
    clear_model();
    add_frame(0, 8'h5A);
    add_idle(3);
    start(0, 8'h5A);
    observe(0, "midrst_after", 0, -1, 8'h00);
    $display("txn midrst   unit=0 data=0x5a busy_cycles=%0d", obs_busy_cnt);

    // Randomized frames against the model
    for (int n = 0; n < 24; n++) begin
      u = int'($urandom_range(0, 2));
      d = 8'($urandom);
      clear_model();
      add_frame(u, d);
      add_idle(1 + int'($urandom_range(0, 4)));
      start(u, d);
      observe(u, "rand", 0, -1, 8'($urandom));
      check_val("rand_busy_cycles", obs_busy_cnt, (u == 0) ? 10 * DIV : 11 * DIV);
      $display("txn rand     unit=%0d data=0x%02h busy_cycles=%0d", u, d, obs_busy_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
